voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
Polyphonic note scheduler that sits between the note-event source (MIDI decoder / sequencer) and a bank of NUM_VOICES voice instances. It accepts note-on/note-off events over a valid/ready handshake and assigns each event to a voice. It drives each voice's gate and tone_freq inputs. Allocation order is: same-note reuse, then a free voice, then round-robin voice stealing. A gate-low hold long enough for the sample-rate envelope generators to see a retrigger is inserted where needed.

Parameters:
NUM_VOICES, 4, number of voices managed (2..16)
FREQ_BITS, 16, width of tone_freq word per voice
NOTE_BITS, 7, width of note number
RETRIG_CYCLES, 512, main_clk cycles gate is held low on retrigger/steal (must exceed one sample_clk period)

Ports:
main_clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
note_valid  in  1  event present
note_ready  out  1  block can accept event (high only in IDLE)
note_on  in  1  1 = note-on, 0 = note-off
note_num  in  NOTE_BITS  note identifier
note_freq  in  FREQ_BITS  tone_freq for this note (ignored on note-off)
all_notes_off  in  1  panic: clear every gate
voice_gate  out  NUM_VOICES  gate per voice
voice_freq  out  NUM_VOICES*FREQ_BITS  tone_freq per voice; voice i at [i*FREQ_BITS +: FREQ_BITS]
voice_note  out  NUM_VOICES*NOTE_BITS  note currently owned by voice i
steal_pulse  out  1  one-cycle pulse when a sounding voice is stolen

Behaviour:
- Reset (async, rst high): all voice_gate=0, voice_freq=0, voice_note=0, steal_ptr=0, steal_pulse=0, state=IDLE, note_ready=1.
- States: IDLE, SCAN, APPLY, RETRIG.
- IDLE: note_ready=1. On note_valid&&note_ready at edge E0, latch note_on/num/freq, clear match/free flags, idx=0, go SCAN.
- SCAN: one voice per cycle, idx 0..NUM_VOICES-1 (edges E1..EN).
  - Record the first index with gate=1 && note==latched num (match).
  - Record the first index with gate=0 (free).
  - After idx=NUM_VOICES-1, go APPLY.
- APPLY (edge E(N+1)):
  - note-on, match found: that voice gate<=0, freq/note updated, go RETRIG.
  - note-on, no match, free found: free voice gate<=1, freq/note updated, go IDLE.
  - note-on, no match, no free: voice steal_ptr gate<=0, freq/note updated, steal_pulse=1 this cycle, steal_ptr<=(steal_ptr+1) mod NUM_VOICES, go RETRIG.
  - note-off, match found: gate<=0, freq/note unchanged, go IDLE.
  - note-off, no match: no change, go IDLE.
- RETRIG: counter runs RETRIG_CYCLES cycles with gate low. On the final count, target gate<=1 and go IDLE.
  - Total event-to-gate-high for retrigger: N+1+RETRIG_CYCLES cycles.
- Latency for a free-voice note-on: gate high N+1 edges after acceptance. note_ready returns high the cycle after the IDLE transition.
- Free voices in release still own their old note; a note-off for that note finds no match (gate=0) and is ignored.
- Voice outputs change only in APPLY, at RETRIG end, or on all_notes_off. voice_freq is never changed on note-off, so release tails keep pitch.
- all_notes_off (level, sampled each edge) has priority over everything:
  - All gates<=0 and state<=IDLE.
  - A latched or in-flight event is dropped, including one mid-RETRIG.
  - freq/note and steal_ptr are retained.
  - note_ready=0 while all_notes_off is high.
- Event arriving while not IDLE: note_ready=0; the source holds note_valid. No event is lost or duplicated.
- steal_ptr wraps from NUM_VOICES-1 to 0. It advances only on a steal.

Test Plan:
1. Reset, then 4 note-ons (notes 60..63, freqs 0x1000..0x1003), each waiting for note_ready -> voices 0..3 gated in order; each gate rises exactly N+1=5 edges after its handshake; steal_pulse never asserted.
2. With voices 0..3 held, note-on 64 freq 0x2000 -> voice 0 gate low for exactly 512 cycles, voice_note0=64, voice_freq0=0x2000, steal_pulse one cycle. Note-on 65 -> voice 1 stolen. Two more steals -> voices 2, 3; the next steal returns to voice 0 (wrap).
3. Voice 2 holding note 62: note-on 62 freq 0x3000 -> voice 2 gate drops 512 cycles then rises with freq 0x3000; other gates are untouched.
4. Note-off 61 -> voice 1 gate low at E5, freq unchanged. A second note-off 61 -> no output change. Note-off 99 (never played) -> no output change.
5. Assert all_notes_off for 1 cycle during RETRIG of scenario 3 -> all gates 0 on the next edge; state returns to IDLE; the retrigger gate never rises; note_ready resumes.
6. Hold note_valid during SCAN with a changing note_num -> the note_num presented at the handshake is taken exactly once. Assert rst mid-SCAN -> all outputs at reset values immediately (asynchronous).

Source files
------------

// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: assigns note events to voices (same-note reuse, free voice,
// then round-robin steal) and holds the gate low long enough for envelopes to retrigger.
module voice_allocator #(
  parameter int NUM_VOICES    = 4,
  parameter int FREQ_BITS     = 16,
  parameter int NOTE_BITS     = 7,
  parameter int RETRIG_CYCLES = 512
) (
  input  logic                            main_clk,
  input  logic                            rst,
  input  logic                            note_valid,
  output logic                            note_ready,
  input  logic                            note_on,
  input  logic [NOTE_BITS-1:0]            note_num,
  input  logic [FREQ_BITS-1:0]            note_freq,
  input  logic                            all_notes_off,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic [NUM_VOICES*FREQ_BITS-1:0] voice_freq,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
  output logic                            steal_pulse
);

  localparam int IDXW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNTW = (RETRIG_CYCLES > 1) ? $clog2(RETRIG_CYCLES + 1) : 1;
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_VOICES - 1);
  localparam logic [CNTW-1:0] CNT_START = CNTW'(RETRIG_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_APPLY, S_RETRIG} state_t;

  state_t                r_state;
  logic                  r_on;
  logic [NOTE_BITS-1:0]  r_num;
  logic [FREQ_BITS-1:0]  r_freq_in;
  logic [IDXW-1:0]       r_idx;
  logic [IDXW-1:0]       r_match_idx;
  logic [IDXW-1:0]       r_free_idx;
  logic [IDXW-1:0]       r_steal_ptr;
  logic [IDXW-1:0]       r_tgt;
  logic                  r_match_found;
  logic                  r_free_found;
  logic [CNTW-1:0]       r_cnt;
  logic [NUM_VOICES-1:0] r_gate;
  logic [FREQ_BITS-1:0]  r_vfreq [NUM_VOICES];
  logic [NOTE_BITS-1:0]  r_vnote [NUM_VOICES];
  logic                  r_steal;

  logic w_hit_match;
  logic w_hit_free;

  assign w_hit_match = r_gate[r_idx] && (r_vnote[r_idx] == r_num);
  assign w_hit_free  = !r_gate[r_idx];

  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_on          <= 1'b0;
      r_num         <= '0;
      r_freq_in     <= '0;
      r_idx         <= '0;
      r_match_idx   <= '0;
      r_free_idx    <= '0;
      r_steal_ptr   <= '0;
      r_tgt         <= '0;
      r_match_found <= 1'b0;
      r_free_found  <= 1'b0;
      r_cnt         <= '0;
      r_gate        <= '0;
      r_steal       <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_vfreq[i] <= '0;
        r_vnote[i] <= '0;
      end
    end else if (all_notes_off) begin
      // Panic drops any in-flight event but keeps pitch/note ownership and steal order.
      r_gate  <= '0;
      r_state <= S_IDLE;
      r_steal <= 1'b0;
    end else begin
      r_steal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (note_valid) begin
            r_on          <= note_on;
            r_num         <= note_num;
            r_freq_in     <= note_freq;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_idx         <= '0;
            r_state       <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!r_match_found && w_hit_match) begin
            r_match_found <= 1'b1;
            r_match_idx   <= r_idx;
          end
          if (!r_free_found && w_hit_free) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
          end
          if (r_idx == LAST_IDX) r_state <= S_APPLY;
          else                   r_idx   <= r_idx + 1'b1;
        end
        S_APPLY: begin
          r_state <= S_IDLE;
          if (r_on) begin
            if (r_match_found) begin
              r_gate[r_match_idx]  <= 1'b0;
              r_vfreq[r_match_idx] <= r_freq_in;
              r_vnote[r_match_idx] <= r_num;
              r_tgt                <= r_match_idx;
              r_cnt                <= CNT_START;
              r_state              <= S_RETRIG;
            end else if (r_free_found) begin
              r_gate[r_free_idx]  <= 1'b1;
              r_vfreq[r_free_idx] <= r_freq_in;
              r_vnote[r_free_idx] <= r_num;
            end else begin
              r_gate[r_steal_ptr]  <= 1'b0;
              r_vfreq[r_steal_ptr] <= r_freq_in;
              r_vnote[r_steal_ptr] <= r_num;
              r_tgt                <= r_steal_ptr;
              r_steal              <= 1'b1;
              r_steal_ptr          <= (r_steal_ptr == LAST_IDX) ? '0 : r_steal_ptr + 1'b1;
              r_cnt                <= CNT_START;
              r_state              <= S_RETRIG;
            end
          end else if (r_match_found) begin
            r_gate[r_match_idx] <= 1'b0;
          end
        end
        S_RETRIG: begin
          if (r_cnt == '0) begin
            r_gate[r_tgt] <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign note_ready  = (r_state == S_IDLE) && !all_notes_off;
  assign voice_gate  = r_gate;
  assign steal_pulse = r_steal;

  always_comb begin
    voice_freq = '0;
    voice_note = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_freq[i*FREQ_BITS +: FREQ_BITS] = r_vfreq[i];
      voice_note[i*NOTE_BITS +: NOTE_BITS] = r_vnote[i];
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a reference voice model predicts each event's
// outcome and timing when it is driven; the observed result is compared when it completes.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int FB = 16;
  localparam int NB = 7;
  localparam int RC = 512;

  logic             main_clk = 1'b0;
  logic             rst;
  logic             note_valid;
  logic             note_ready;
  logic             note_on;
  logic [NB-1:0]    note_num;
  logic [FB-1:0]    note_freq;
  logic             all_notes_off;
  logic [NV-1:0]    voice_gate;
  logic [NV*FB-1:0] voice_freq;
  logic [NV*NB-1:0] voice_note;
  logic             steal_pulse;

  voice_allocator #(.NUM_VOICES(NV), .FREQ_BITS(FB), .NOTE_BITS(NB), .RETRIG_CYCLES(RC)) dut (
    .main_clk      (main_clk),
    .rst           (rst),
    .note_valid    (note_valid),
    .note_ready    (note_ready),
    .note_on       (note_on),
    .note_num      (note_num),
    .note_freq     (note_freq),
    .all_notes_off (all_notes_off),
    .voice_gate    (voice_gate),
    .voice_freq    (voice_freq),
    .voice_note    (voice_note),
    .steal_pulse   (steal_pulse)
  );

  always #5 main_clk = ~main_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference voice model
  logic [NV-1:0] m_gate;
  logic [FB-1:0] m_freq [NV];
  logic [NB-1:0] m_note [NV];
  int            m_ptr;

  typedef struct {
    string         tag;
    int            tgt;
    int            fall_k;
    int            rise_k;
    int            ready_k;
    int            steals;
    logic [NV-1:0] gate;
    logic [63:0]   freq;
    logic [63:0]   note;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [63:0] pack_freq();
    logic [63:0] r = '0;
    for (int i = 0; i < NV; i++) r[i*FB +: FB] = m_freq[i];
    return r;
  endfunction

  function automatic logic [63:0] pack_note();
    logic [63:0] r = '0;
    for (int i = 0; i < NV; i++) r[i*NB +: NB] = m_note[i];
    return r;
  endfunction

  task automatic model_reset();
    m_gate = '0;
    m_ptr  = 0;
    for (int i = 0; i < NV; i++) begin
      m_freq[i] = '0;
      m_note[i] = '0;
    end
  endtask

  task automatic model_event(input string tag, input bit on, input int num, input int freq);
    exp_t e;
    int match = -1;
    int free  = -1;
    for (int i = 0; i < NV; i++) begin
      if (match < 0 && m_gate[i] && m_note[i] == NB'(num)) match = i;
      if (free < 0 && !m_gate[i]) free = i;
    end
    e.tag = tag; e.tgt = 0; e.fall_k = -1; e.rise_k = -1; e.ready_k = NV + 1; e.steals = 0;
    if (on) begin
      if (match >= 0) begin
        e.tgt = match; e.fall_k = NV + 1; e.rise_k = NV + 1 + RC; e.ready_k = NV + 1 + RC;
      end else if (free >= 0) begin
        e.tgt = free; e.rise_k = NV + 1;
      end else begin
        e.tgt = m_ptr; e.fall_k = NV + 1; e.rise_k = NV + 1 + RC; e.ready_k = NV + 1 + RC;
        e.steals = 1; m_ptr = (m_ptr + 1) % NV;
      end
      m_gate[e.tgt] = 1'b1;
      m_freq[e.tgt] = FB'(freq);
      m_note[e.tgt] = NB'(num);
    end else if (match >= 0) begin
      e.tgt = match; e.fall_k = NV + 1;
      m_gate[match] = 1'b0;
    end
    e.gate = m_gate;
    e.freq = pack_freq();
    e.note = pack_note();
    sb_q.push_back(e);
  endtask

  task automatic handshake(input bit on, input int num, input int freq);
    int k = 0;
    @(negedge main_clk);
    note_valid = 1'b1; note_on = on; note_num = NB'(num); note_freq = FB'(freq);
    while (!note_ready && k < 2000) begin
      @(negedge main_clk);
      k++;
    end
  endtask

  task automatic run_event(input string tag, input bit on, input int num, input int freq,
                           input bit jitter);
    exp_t e;
    int   tgt;
    int   fall_k = -1, rise_k = -1, ready_k = -1, steals = 0;
    logic prev;
    handshake(on, num, freq);
    check_val({tag, "_hs"}, 64'(note_ready), 64'd1);
    model_event(tag, on, num, freq);
    tgt = sb_q[sb_q.size() - 1].tgt;
    @(posedge main_clk); #1;
    note_valid = jitter;
    if (jitter) note_num = NB'($urandom_range(0, 127));
    prev = voice_gate[tgt];
    for (int k = 1; k <= NV + RC + 50; k++) begin
      @(posedge main_clk); #1;
      if (steal_pulse) steals++;
      if (prev && !voice_gate[tgt] && fall_k < 0) fall_k = k;
      if (!prev && voice_gate[tgt] && rise_k < 0) rise_k = k;
      prev = voice_gate[tgt];
      if (note_ready) begin
        ready_k = k;
        break;
      end
      if (jitter) begin
        note_valid = 1'b1; note_on = 1'b1; note_num = NB'($urandom_range(0, 127));
      end
    end
    e = sb_q.pop_front();
    check_val({e.tag, "_fall"},   64'(fall_k),  64'(e.fall_k));
    check_val({e.tag, "_rise"},   64'(rise_k),  64'(e.rise_k));
    check_val({e.tag, "_ready"},  64'(ready_k), 64'(e.ready_k));
    check_val({e.tag, "_steals"}, 64'(steals),  64'(e.steals));
    check_val({e.tag, "_gate"},   64'(voice_gate), 64'(e.gate));
    check_val({e.tag, "_freq"},   voice_freq, e.freq);
    check_val({e.tag, "_note"},   64'(voice_note), e.note);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_gate"},  64'(voice_gate), 64'd0);
    check_val({tag, "_freq"},  voice_freq, 64'd0);
    check_val({tag, "_note"},  64'(voice_note), 64'd0);
    check_val({tag, "_steal"}, 64'(steal_pulse), 64'd0);
    check_val({tag, "_ready"}, 64'(note_ready), 64'd1);
  endtask

  initial begin
    int rises;
    rst = 1'b0; note_valid = 1'b0; note_on = 1'b0; note_num = '0; note_freq = '0;
    all_notes_off = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #20;
    check_reset_outputs("rst0");
    @(negedge main_clk); rst = 1'b0;

    // Fill all voices
    for (int i = 0; i < 4; i++) run_event($sformatf("fill%0d", i), 1'b1, 60 + i, 'h1000 + i, 1'b0);
    // Same-note retrigger on voice 2
    run_event("retrig62", 1'b1, 62, 'h3000, 1'b0);
    // Five steals: voices 0..3 then wrap to 0
    for (int i = 0; i < 5; i++) run_event($sformatf("steal%0d", i), 1'b1, 64 + i, 'h2000 + i, 1'b0);
    // Note-offs: matching, repeated (released voice), never played
    run_event("off65",   1'b0, 65, 'h7777, 1'b0);
    run_event("off65b",  1'b0, 65, 'h7777, 1'b0);
    run_event("off99",   1'b0, 99, 'h7777, 1'b0);

    // Panic during a retrigger of voice 2 (holding note 66)
    handshake(1'b1, 66, 'h3100);
    check_val("panic_hs", 64'(note_ready), 64'd1);
    @(posedge main_clk); #1;
    note_valid = 1'b0;
    repeat (NV + 1 + 10) @(posedge main_clk);
    #1;
    check_val("panic_pre_gate2", 64'(voice_gate[2]), 64'd0);
    check_val("panic_pre_freq2", 64'(voice_freq[2*FB +: FB]), 64'h3100);
    all_notes_off = 1'b1;
    #1;
    check_val("panic_ready_low", 64'(note_ready), 64'd0);
    @(posedge main_clk); #1;
    all_notes_off = 1'b0;
    #1;
    check_val("panic_gates", 64'(voice_gate), 64'd0);
    check_val("panic_ready_back", 64'(note_ready), 64'd1);
    m_gate = '0; m_freq[2] = 16'h3100; m_note[2] = 7'd66;
    rises = 0;
    repeat (RC + 20) begin
      @(posedge main_clk); #1;
      if (voice_gate != '0) rises++;
    end
    check_val("panic_no_rise", 64'(rises), 64'd0);
    check_val("panic_freq", voice_freq, pack_freq());
    check_val("panic_note", 64'(voice_note), pack_note());

    // Held valid with changing note_num while busy; only the handshake value counts
    run_event("jit70", 1'b1, 70, 'h4000, 1'b1);
    run_event("jit71", 1'b1, 71, 'h4001, 1'b0);
    // Steal pointer was retained through the panic (points at voice 1)
    run_event("fill72", 1'b1, 72, 'h4002, 1'b0);
    run_event("fill73", 1'b1, 73, 'h4003, 1'b0);
    run_event("steal74", 1'b1, 74, 'h4004, 1'b0);

    // Asynchronous reset in the middle of a scan
    handshake(1'b1, 80, 'h5000);
    @(posedge main_clk); #1;
    note_valid = 1'b0;
    @(posedge main_clk); #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge main_clk); rst = 1'b0;
    model_reset();
    run_event("post_rst", 1'b1, 81, 'h5001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
